// File: rtl/text_render_pipe.sv
// text_render_pipe
//   Text-mode renderer that sits between vga_sync and the VGA pins. It holds a writable
//   tile RAM (character plus foreground/background colour per cell) and drives an
//   external font ROM with a 1-cycle read latency. It adds per-cell colour, integer zoom,
//   a blinking cursor and an optional one-pixel screen border.
//
//   rgb/hsync/vsync come out of four register stages. An input sampled on edge N
//   is visible at the outputs after edge N+3:
//     S1 (edge N)   register the inputs and the derived cell/glyph indices
//     S2 (edge N+1) tile RAM read (read-first); font_char/row/col registered
//     S3 (edge N+2) the font ROM registers font_bit; attributes and flags move on
//     S4 (edge N+3) the colour is selected from font_bit and registered into rgb
//
// Ports
//   px_clk            pixel clock, the only clock
//   rst               synchronous reset, active-high
//   hsync_i, vsync_i  active-low syncs from vga_sync
//   activevideo_i     visible-area flag
//   px_x_i, px_y_i    current pixel coordinates
//   wr_en, wr_addr,   tile RAM write port, word = {char[7:0], fg, bg},
//   wr_data           address = row*COLS+col
//   cur_en, cur_col,  cursor enable and cell position
//   cur_row
//   font_char/row/col glyph lookup sent to the external font ROM
//   font_bit          ROM pixel returned one cycle after font_* changes
//   rgb, hsync, vsync registered VGA outputs
module text_render_pipe #(
    parameter int unsigned       ZOOM         = 1,
    parameter int unsigned       COLS         = 40,
    parameter int unsigned       ROWS         = 30,
    parameter int unsigned       CBITS        = 3,
    parameter int unsigned       BLINK_FRAMES = 30,
    parameter bit                BORDER_EN    = 1'b1,
    parameter logic [CBITS-1:0]  BORDER_RGB   = CBITS'(1),
    localparam int unsigned      AW           = $clog2(COLS * ROWS)
) (
    input  logic                   px_clk,
    input  logic                   rst,
    input  logic                   hsync_i,
    input  logic                   vsync_i,
    input  logic                   activevideo_i,
    input  logic [9:0]             px_x_i,
    input  logic [9:0]             px_y_i,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [8+2*CBITS-1:0]   wr_data,
    input  logic                   cur_en,
    input  logic [7:0]             cur_col,
    input  logic [7:0]             cur_row,
    output logic [7:0]             font_char,
    output logic [2:0]             font_row,
    output logic [2:0]             font_col,
    input  logic                   font_bit,
    output logic [CBITS-1:0]       rgb,
    output logic                   hsync,
    output logic                   vsync
);

    localparam int unsigned SH     = ZOOM + 3;
    localparam int unsigned NCELL  = COLS * ROWS;
    localparam int unsigned DW     = 8 + 2 * CBITS;
    localparam int unsigned BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [9:0]  COLS_W = 10'(COLS);
    localparam logic [9:0]  ROWS_W = 10'(ROWS);

    // ---------------------------------------------------------------- S1 decode
    logic [9:0]    w_cx;
    logic [9:0]    w_cy;
    logic [2:0]    w_gx;
    logic [2:0]    w_gy;
    logic [AW-1:0] w_addr;
    logic          w_oob;
    logic          w_border;
    logic          w_cursor;
    logic          w_tick;

    always_comb begin
        w_cx     = px_x_i >> SH;
        w_cy     = px_y_i >> SH;
        w_gx     = 3'(px_x_i >> ZOOM);
        w_gy     = 3'(px_y_i >> ZOOM);
        w_addr   = AW'(20'(w_cy) * 20'(COLS) + 20'(w_cx));
        w_oob    = (w_cx >= COLS_W) || (w_cy >= ROWS_W);
        w_border = BORDER_EN && ((px_x_i == 10'd0) || (px_x_i == 10'd639) ||
                                 (px_y_i == 10'd0) || (px_y_i == 10'd479));
        // An out-of-range cursor position never matches a cell.
        w_cursor = cur_en &&
                   ({2'b00, cur_col} == w_cx) && ({2'b00, cur_row} == w_cy) &&
                   ({2'b00, cur_col} < COLS_W) && ({2'b00, cur_row} < ROWS_W);
        // Frame tick on the falling edge of vsync, seen against the S1 copy.
        w_tick   = r1_vsync && !vsync_i;
    end

    // ---------------------------------------------------------------- pipeline regs
    logic          r1_active, r1_hsync, r1_vsync, r1_border, r1_oob, r1_cursor;
    logic [AW-1:0] r1_addr;
    logic [2:0]    r1_gx, r1_gy;

    logic          r2_active, r2_hsync, r2_vsync, r2_border, r2_oob, r2_cursor;
    logic [2:0]    r_font_row, r_font_col;

    logic             r3_active, r3_hsync, r3_vsync, r3_border, r3_oob, r3_cursor;
    logic [CBITS-1:0] r3_fg, r3_bg;

    logic [CBITS-1:0] r_rgb;
    logic             r_hsync, r_vsync;

    logic [BW-1:0]    r_blink_cnt;
    logic             r_blink_on;

    // Tile RAM; deliberately not reset so its contents survive a pipeline reset.
    logic [DW-1:0]    r_mem [NCELL];
    logic [DW-1:0]    r_tile;

    always_ff @(posedge px_clk) begin
        // Addresses past the last cell are dropped rather than wrapped.
        if (wr_en && (32'(wr_addr) < NCELL)) begin
            r_mem[wr_addr] <= wr_data;
        end
        // Read-first: a same-cycle write to this address is seen on the next read.
        r_tile <= r_mem[r1_addr];
    end

    logic [CBITS-1:0] w_rgb;

    always_comb begin
        w_rgb = '0;
        if (!r3_active) begin
            w_rgb = '0;
        end else if (r3_border) begin
            w_rgb = BORDER_RGB;
        end else if (r3_oob) begin
            w_rgb = '0;
        end else if (r3_cursor && r_blink_on) begin
            w_rgb = font_bit ? r3_bg : r3_fg;
        end else begin
            w_rgb = font_bit ? r3_fg : r3_bg;
        end
    end

    always_ff @(posedge px_clk) begin
        if (rst) begin
            r1_active   <= 1'b0;
            r1_hsync    <= 1'b1;
            r1_vsync    <= 1'b1;
            r1_border   <= 1'b0;
            r1_oob      <= 1'b0;
            r1_cursor   <= 1'b0;
            r1_addr     <= '0;
            r1_gx       <= '0;
            r1_gy       <= '0;
            r2_active   <= 1'b0;
            r2_hsync    <= 1'b1;
            r2_vsync    <= 1'b1;
            r2_border   <= 1'b0;
            r2_oob      <= 1'b0;
            r2_cursor   <= 1'b0;
            r_font_row  <= '0;
            r_font_col  <= '0;
            r3_active   <= 1'b0;
            r3_hsync    <= 1'b1;
            r3_vsync    <= 1'b1;
            r3_border   <= 1'b0;
            r3_oob      <= 1'b0;
            r3_cursor   <= 1'b0;
            r3_fg       <= '0;
            r3_bg       <= '0;
            r_rgb       <= '0;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            // S1
            r1_active  <= activevideo_i;
            r1_hsync   <= hsync_i;
            r1_vsync   <= vsync_i;
            r1_border  <= w_border;
            r1_oob     <= w_oob;
            r1_cursor  <= w_cursor;
            r1_addr    <= w_oob ? '0 : w_addr;
            r1_gx      <= w_gx;
            r1_gy      <= w_gy;
            // S2
            r2_active  <= r1_active;
            r2_hsync   <= r1_hsync;
            r2_vsync   <= r1_vsync;
            r2_border  <= r1_border;
            r2_oob     <= r1_oob;
            r2_cursor  <= r1_cursor;
            r_font_row <= r1_gy;
            r_font_col <= r1_gx;
            // S3
            r3_active  <= r2_active;
            r3_hsync   <= r2_hsync;
            r3_vsync   <= r2_vsync;
            r3_border  <= r2_border;
            r3_oob     <= r2_oob;
            r3_cursor  <= r2_cursor;
            r3_fg      <= r_tile[2*CBITS-1:CBITS];
            r3_bg      <= r_tile[CBITS-1:0];
            // S4
            r_rgb      <= w_rgb;
            r_hsync    <= r3_hsync;
            r_vsync    <= r3_vsync;
            // Cursor blink
            if (w_tick) begin
                if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink_on  <= !r_blink_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    assign font_char = r_tile[DW-1 -: 8];
    assign font_row  = r_font_row;
    assign font_col  = r_font_col;
    assign rgb       = r_rgb;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;

endmodule

// File: tb/tb_text_render_pipe.sv
// Directed bench for text_render_pipe. Three instances share the stimulus:
//   u_a  ZOOM=0, 40x30, BLINK_FRAMES=2, border on
//   u_b  ZOOM=1, 30x30, border on
//   u_c  ZOOM=1, 40x30, border off
// Each instance has its own font ROM stub with one cycle of latency.
module tb_text_render_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync_i, vsync_i, av;
    logic [9:0]  px_x, px_y;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [13:0] wr_data;
    logic        cur_en;
    logic [7:0]  cur_col, cur_row;

    logic [7:0]  a_char, b_char, c_char;
    logic [2:0]  a_row, b_row, c_row, a_col, b_col, c_col;
    logic        a_bit, b_bit, c_bit;
    logic [2:0]  a_rgb, b_rgb, c_rgb;
    logic        a_hs, a_vs, b_hs, b_vs, c_hs, c_vs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // 'A' (0x41): lit only in column 3 for rows 0..6. Other codes: bit = char[col].
    function automatic logic rom_f(input logic [7:0] c, input logic [2:0] r,
                                   input logic [2:0] col);
        if (c == 8'h41) return (col == 3'd3) && (r != 3'd7);
        return c[col];
    endfunction

    always_ff @(posedge clk) begin
        a_bit <= rom_f(a_char, a_row, a_col);
        b_bit <= rom_f(b_char, b_row, b_col);
        c_bit <= rom_f(c_char, c_row, c_col);
    end

    text_render_pipe #(.ZOOM(0), .COLS(40), .ROWS(30), .CBITS(3), .BLINK_FRAMES(2),
                       .BORDER_EN(1'b1), .BORDER_RGB(3'b001)) u_a (
        .px_clk(clk), .rst(rst), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .activevideo_i(av), .px_x_i(px_x), .px_y_i(px_y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_en(cur_en), .cur_col(cur_col), .cur_row(cur_row),
        .font_char(a_char), .font_row(a_row), .font_col(a_col), .font_bit(a_bit),
        .rgb(a_rgb), .hsync(a_hs), .vsync(a_vs)
    );

    text_render_pipe #(.ZOOM(1), .COLS(30), .ROWS(30), .CBITS(3), .BLINK_FRAMES(30),
                       .BORDER_EN(1'b1), .BORDER_RGB(3'b001)) u_b (
        .px_clk(clk), .rst(rst), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .activevideo_i(av), .px_x_i(px_x), .px_y_i(px_y),
        .wr_en(wr_en), .wr_addr(wr_addr[9:0]), .wr_data(wr_data),
        .cur_en(cur_en), .cur_col(cur_col), .cur_row(cur_row),
        .font_char(b_char), .font_row(b_row), .font_col(b_col), .font_bit(b_bit),
        .rgb(b_rgb), .hsync(b_hs), .vsync(b_vs)
    );

    text_render_pipe #(.ZOOM(1), .COLS(40), .ROWS(30), .CBITS(3), .BLINK_FRAMES(30),
                       .BORDER_EN(1'b0), .BORDER_RGB(3'b001)) u_c (
        .px_clk(clk), .rst(rst), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .activevideo_i(av), .px_x_i(px_x), .px_y_i(px_y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_en(cur_en), .cur_col(cur_col), .cur_row(cur_row),
        .font_char(c_char), .font_row(c_row), .font_col(c_col), .font_bit(c_bit),
        .rgb(c_rgb), .hsync(c_hs), .vsync(c_vs)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic [9:0] x, input logic [9:0] y, input logic a);
        px_x = x;
        px_y = y;
        av   = a;
    endtask

    task automatic wr(input logic [10:0] addr, input logic [13:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; hsync_i = 1'b0; vsync_i = 1'b1; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; cur_en = 1'b0; cur_col = '0; cur_row = '0;
        set_px(10'd3, 10'd2, 1'b0);
        step(3);
        total++;
        if (a_rgb !== 3'b000) begin
            bad++; $display("FAIL reset_rgb got=%b want=000", a_rgb);
        end
        total++;
        if (a_hs !== 1'b1 || a_vs !== 1'b1) begin
            bad++; $display("FAIL reset_sync got=%b%b want=11", a_hs, a_vs);
        end
        rst = 1'b0;
        step(3);
        total++;
        if (a_hs !== 1'b1) begin
            bad++; $display("FAIL latency_early got=%b want=1", a_hs);
        end
        step(1);
        total++;
        if (a_hs !== 1'b0) begin
            bad++; $display("FAIL latency_4 got=%b want=0", a_hs);
        end
        hsync_i = 1'b1;
        step(4);
    endtask

    task automatic test_pixel;
        cur_en = 1'b0;
        wr(11'd0, {8'h41, 3'b010, 3'b000});
        set_px(10'd3, 10'd2, 1'b1);
        step(4);
        total++;
        if (a_rgb !== 3'b010) begin
            bad++; $display("FAIL px_fg got=%b want=010", a_rgb);
        end
        total++;
        if (a_char !== 8'h41 || a_row !== 3'd2 || a_col !== 3'd3) begin
            bad++; $display("FAIL font_idx got=%h/%0d/%0d want=41/2/3", a_char, a_row, a_col);
        end
        set_px(10'd4, 10'd2, 1'b1);
        step(4);
        total++;
        if (a_rgb !== 3'b000) begin
            bad++; $display("FAIL px_bg got=%b want=000", a_rgb);
        end
        // Row 1, col 1 -> addr 41; 0x0F lit in columns 0..3.
        wr(11'd41, {8'h0F, 3'b110, 3'b001});
        set_px(10'd10, 10'd9, 1'b1);
        step(4);
        total++;
        if (a_rgb !== 3'b110) begin
            bad++; $display("FAIL cell41_fg got=%b want=110", a_rgb);
        end
        set_px(10'd13, 10'd9, 1'b1);
        step(4);
        total++;
        if (a_rgb !== 3'b001) begin
            bad++; $display("FAIL cell41_bg got=%b want=001", a_rgb);
        end
    endtask

    task automatic test_cursor;
        logic [2:0] exp;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        wr(11'd0, {8'h41, 3'b010, 3'b101});
        cur_en = 1'b1; cur_col = 8'd0; cur_row = 8'd0;
        set_px(10'd3, 10'd2, 1'b1);
        for (int f = 0; f < 5; f++) begin
            step(4);
            exp = ((f % 4) < 2) ? 3'b101 : 3'b010;
            total++;
            if (a_rgb !== exp) begin
                bad++; $display("FAIL blink_f%0d got=%b want=%b", f, a_rgb, exp);
            end
            vsync_i = 1'b0;
            step(1);
            vsync_i = 1'b1;
            step(1);
        end
        // Five ticks in: blink phase is on again.
        cur_en = 1'b0;
        step(4);
        total++;
        if (a_rgb !== 3'b010) begin
            bad++; $display("FAIL cur_disabled got=%b want=010", a_rgb);
        end
        cur_en = 1'b1; cur_col = 8'd200;
        step(4);
        total++;
        if (a_rgb !== 3'b010) begin
            bad++; $display("FAIL cur_out_of_range got=%b want=010", a_rgb);
        end
        cur_col = 8'd0; cur_row = 8'd1;
        step(4);
        total++;
        if (a_rgb !== 3'b010) begin
            bad++; $display("FAIL cur_other_cell got=%b want=010", a_rgb);
        end
        cur_row = 8'd0;
        step(4);
        total++;
        if (a_rgb !== 3'b101) begin
            bad++; $display("FAIL cur_back got=%b want=101", a_rgb);
        end
        cur_en = 1'b0;
    endtask

    task automatic test_rw_collision;
        wr(11'd5, {8'h10, 3'b111, 3'b100});
        set_px(10'd42, 10'd2, 1'b1);
        step(4);
        total++;
        if (a_char !== 8'h10 || a_rgb !== 3'b100) begin
            bad++; $display("FAIL rw_pre got=%h/%b want=10/100", a_char, a_rgb);
        end
        wr_en = 1'b1; wr_addr = 11'd5; wr_data = {8'h22, 3'b111, 3'b011};
        step(1);
        wr_en = 1'b0;
        total++;
        if (a_char !== 8'h10) begin
            bad++; $display("FAIL rw_read_first got=%h want=10", a_char);
        end
        step(1);
        total++;
        if (a_char !== 8'h22) begin
            bad++; $display("FAIL rw_new got=%h want=22", a_char);
        end
        step(3);
        total++;
        if (a_rgb !== 3'b011) begin
            bad++; $display("FAIL rw_new_rgb got=%b want=011", a_rgb);
        end
    endtask

    task automatic test_zoom_border;
        wr(11'd39, {8'h41, 3'b110, 3'b011});
        set_px(10'd639, 10'd4, 1'b1);
        step(4);
        total++;
        if (c_rgb !== 3'b011 || c_col !== 3'd7 || c_row !== 3'd2) begin
            bad++; $display("FAIL zoom_x639 got=%b/%0d/%0d want=011/7/2", c_rgb, c_col, c_row);
        end
        set_px(10'd631, 10'd4, 1'b1);
        step(4);
        total++;
        if (c_rgb !== 3'b110) begin
            bad++; $display("FAIL zoom_x631 got=%b want=110", c_rgb);
        end
        set_px(10'd500, 10'd4, 1'b1);
        step(4);
        total++;
        if (b_rgb !== 3'b000) begin
            bad++; $display("FAIL zoom_oob got=%b want=000", b_rgb);
        end
        set_px(10'd0, 10'd4, 1'b1);
        step(4);
        total++;
        if (a_rgb !== 3'b001 || b_rgb !== 3'b001) begin
            bad++; $display("FAIL border_x0 got=%b/%b want=001/001", a_rgb, b_rgb);
        end
        total++;
        if (c_rgb !== 3'b101) begin
            bad++; $display("FAIL no_border_x0 got=%b want=101", c_rgb);
        end
        set_px(10'd100, 10'd479, 1'b1);
        step(4);
        total++;
        if (a_rgb !== 3'b001) begin
            bad++; $display("FAIL border_y479 got=%b want=001", a_rgb);
        end
    endtask

    task automatic test_inactive_oob_write;
        set_px(10'd3, 10'd2, 1'b0);
        step(4);
        total++;
        if (a_rgb !== 3'b000) begin
            bad++; $display("FAIL inactive got=%b want=000", a_rgb);
        end
        set_px(10'd400, 10'd2, 1'b1);
        step(4);
        total++;
        if (a_rgb !== 3'b000) begin
            bad++; $display("FAIL oob_x400 got=%b want=000", a_rgb);
        end
        wr(11'd1200, {8'h77, 3'b111, 3'b111});
        set_px(10'd3, 10'd2, 1'b1);
        step(4);
        total++;
        if (a_char !== 8'h41 || a_rgb !== 3'b010) begin
            bad++; $display("FAIL wr_oob got=%h/%b want=41/010", a_char, a_rgb);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] xs [4];
        logic [9:0] ys [4];
        logic       as [4];
        logic [2:0] ex [4];
        xs = '{10'd3, 10'd4, 10'd10, 10'd3};
        ys = '{10'd2, 10'd2, 10'd9, 10'd2};
        as = '{1'b1, 1'b1, 1'b1, 1'b0};
        ex = '{3'b010, 3'b101, 3'b110, 3'b000};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                set_px(xs[i], ys[i], as[i]);
                hsync_i = i[0];
            end
            step(1);
            if (i >= 3) begin
                total++;
                if (a_rgb !== ex[i-3] || a_hs !== ((i - 3) % 2 == 1)) begin
                    bad++;
                    $display("FAIL b2b_%0d got=%b/%b want=%b/%b", i - 3, a_rgb, a_hs,
                             ex[i-3], ((i - 3) % 2 == 1));
                end
            end
        end
        hsync_i = 1'b1;
    endtask

    initial begin
        test_reset;
        test_pixel;
        test_cursor;
        test_rw_collision;
        test_zoom_border;
        test_inactive_oob_write;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
